hsiao_code_encoder_pipe: RTL and testbench
==========================================

# hsiao_code_encoder_pipe

Streaming Hsiao SEC-DED (13,8) encoder for the memory write path. It is the write-side counterpart of the team's Hsiao decoder and produces codewords that decode with zero syndrome. Data enters on a valid/ready interface and is encoded in one cycle into a 2-entry output FIFO. An armable error-injection mask lets the bench and BIST corrupt selected codewords to exercise the decoder's correct/detect paths.

## Interface
- `COUNT_W`, default 16: width of the emitted-codeword counter.
- `clk`  in  1: clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `in_valid`  in  1: `in_data` is valid.
- `in_ready`  out  1: the block can accept a word (FIFO not full).
- `in_data`  in  8: data byte to encode.
- `out_valid`  out  1: `out_code` holds a codeword.
- `out_ready`  in  1: downstream accepts `out_code`.
- `out_code`  out  13: codeword; `[12:5]` = data `[7:0]`, `[4:0]` = check bits c4..c0.
- `inj_load`  in  1: one-cycle pulse that loads `inj_mask` and arms injection.
- `inj_mask`  in  13: XOR mask applied to the next accepted codeword.
- `inj_armed`  out  1: an injection mask is pending.
- `code_count`  out  COUNT_W: number of codewords emitted (output handshakes).

## Operation
- Check bits are computed combinationally from `in_data` (d = `in_data`):
  - c4 = d7^d6^d5^d4
  - c3 = d7^d3^d2^d1
  - c2 = d6^d5^d2^d1^d0
  - c1 = d6^d4^d3^d1^d0
  - c0 = d7^d5^d4^d3^d2^d0
- Accept: `in_valid && in_ready`. The word {d, c4..c0} is XORed with the pending mask when `inj_armed` is high, then written at the FIFO tail.
- Emit: `out_valid && out_ready` pops the FIFO head and increments `code_count`, which wraps modulo 2^COUNT_W.
- FIFO:
  - 2 entries, occupancy 0..2, circular pointers wrap 1→0.
  - `out_valid` = occupancy≠0.
  - `in_ready` = occupancy≠2. It depends only on state, so it is never combinationally dependent on `out_ready`.
- Simultaneous push and pop:
  - Occupancy is unchanged.
  - When full, no push can occur because `in_ready`=0, even if `out_ready` is high that cycle.
- Injection state machine (IDLE/ARMED):
  - IDLE → ARMED on `inj_load`, which latches `inj_mask`.
  - ARMED → IDLE on the first accept; the latched mask is applied to exactly that word.
  - `inj_load` while ARMED overwrites the mask and stays ARMED.
  - `inj_load` in the same cycle as an accept: the accepted word uses the old state (corrupted only if already ARMED). The new mask is latched and the block ends ARMED for the next word.
  - A mask of 0 is legal; it arms and consumes one word with no corruption.
- The encoder never inspects `out_code` contents. Injected words are treated like any other word.

## Timing
- Reset (async assert, sync release):
  - Occupancy 0, `out_valid`=0, `in_ready`=1, `out_code`=0.
  - `inj_armed`=0, mask=0, `code_count`=0.
- Reset asserted mid-stream discards all FIFO contents and any pending injection.
- Latency: a word accepted at edge N is presented on `out_code` with `out_valid`=1 after edge N when the FIFO was empty.
- Throughput: 1 word/cycle sustained while `out_ready`=1.
- Stability: `out_code` and `out_valid` hold stable while `out_valid && !out_ready`.
- `in_ready` drops the cycle after the second unpopped word is accepted. It rises the cycle after a pop from full.
- `inj_armed` updates at the clock edge following the load or accept.

## Test plan
- **Reset and basic encode.** Hold `rst_n`=0 and check all outputs are at their reset values with `in_ready`=1. Then, with `out_ready`=1, send 0x00, 0xFF, 0x01, 0x80.
  - Required response: `out_code` = 0x0000, 0x1FE6, 0x0027, 0x1019, each one cycle after accept; `code_count`=4.
- **Backpressure.** Hold `out_ready`=0 and send 0x01, 0x80, 0xFF.
  - Required response: the first two are accepted and `in_ready`=0 thereafter; 0xFF stalls.
  - Raise `out_ready`: outputs are 0x0027, 0x1019, 0x1FE6 in order, with no loss or duplication.
- **Full with simultaneous pop.** With the FIFO full, set `out_ready`=1 and `in_valid`=1.
  - Required response: the push is refused that cycle, accepted the next cycle, and occupancy never exceeds 2.
- **Injection.**
  - `inj_load` with mask 0x0020, then send 0x00, 0x00: outputs 0x0020 then 0x0000, and `inj_armed` falls after the first accept.
  - Mask 0x0003 on 0xFF gives 0x1FE5.
- **Injection corner cases.**
  - `inj_load` coincident with an accept while IDLE: that word is clean, the next is corrupted.
  - A double `inj_load` while ARMED: only the second mask is applied.
- **Reset mid-operation and sweep.**
  - Assert `rst_n` with 2 words queued and injection armed: outputs clear immediately and nothing is emitted after release.
  - Random sweep of all 256 data values: every `out_code` (without injection) must yield zero syndrome through the team decoder.

Source files
------------

// File: rtl/hsiao_code_encoder_pipe.sv
// rtl/hsiao_code_encoder_pipe.sv - Hsiao (13,8) SEC-DED streaming encoder with 2-entry FIFO and error injection
module hsiao_code_encoder_pipe #(
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [7:0]         in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [12:0]        out_code,
    input  logic               inj_load,
    input  logic [12:0]        inj_mask,
    output logic               inj_armed,
    output logic [COUNT_W-1:0] code_count
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_ARMED = 1'b1
    } inj_state_t;

    inj_state_t         r_state;
    inj_state_t         w_state_nxt;
    logic [12:0]        r_mask;
    logic [12:0]        w_mask_nxt;

    logic [12:0]        r_mem [2];
    logic               r_wr_ptr;
    logic               r_rd_ptr;
    logic [1:0]         r_occ;
    logic [COUNT_W-1:0] r_count;

    logic               w_push;
    logic               w_pop;
    logic [4:0]         w_chk;
    logic [12:0]        w_word;

    assign in_ready   = (r_occ != 2'd2);
    assign out_valid  = (r_occ != 2'd0);
    assign out_code   = out_valid ? r_mem[r_rd_ptr] : 13'd0;
    assign inj_armed  = (r_state == S_ARMED);
    assign code_count = r_count;

    assign w_push = in_valid && in_ready;
    assign w_pop  = out_valid && out_ready;

    assign w_chk[4] = in_data[7] ^ in_data[6] ^ in_data[5] ^ in_data[4];
    assign w_chk[3] = in_data[7] ^ in_data[3] ^ in_data[2] ^ in_data[1];
    assign w_chk[2] = in_data[6] ^ in_data[5] ^ in_data[2] ^ in_data[1] ^ in_data[0];
    assign w_chk[1] = in_data[6] ^ in_data[4] ^ in_data[3] ^ in_data[1] ^ in_data[0];
    assign w_chk[0] = in_data[7] ^ in_data[5] ^ in_data[4] ^ in_data[3] ^ in_data[2] ^ in_data[0];

    // The accepted word sees the mask as it stood before this edge's load.
    assign w_word = {in_data, w_chk} ^ ((r_state == S_ARMED) ? r_mask : 13'd0);

    always_comb begin
        w_state_nxt = r_state;
        w_mask_nxt  = r_mask;
        if (inj_load) begin
            w_state_nxt = S_ARMED;
            w_mask_nxt  = inj_mask;
        end else if (w_push && (r_state == S_ARMED)) begin
            w_state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_mask  <= 13'd0;
        end else begin
            r_state <= w_state_nxt;
            r_mask  <= w_mask_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0] <= 13'd0;
            r_mem[1] <= 13'd0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_occ    <= 2'd0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_word;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
                r_count  <= r_count + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase
        end
    end

endmodule

// File: tb/tb_hsiao_code_encoder_pipe.sv
// tb/tb_hsiao_code_encoder_pipe.sv - scoreboard bench for hsiao_code_encoder_pipe
module tb_hsiao_code_encoder_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [12:0] out_code;
    logic        inj_load;
    logic [12:0] inj_mask;
    logic        inj_armed;
    logic [15:0] code_count;

    hsiao_code_encoder_pipe #(.COUNT_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_code   (out_code),
        .inj_load   (inj_load),
        .inj_mask   (inj_mask),
        .inj_armed  (inj_armed),
        .code_count (code_count)
    );

    always #5 clk = ~clk;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [12:0] sb[$];
    int          tb_occ   = 0;
    logic        tb_armed = 1'b0;
    logic [12:0] tb_mask  = 13'd0;
    logic [15:0] tb_cnt   = 16'd0;
    logic        use_exp  = 1'b0;
    logic [12:0] exp_code = 13'd0;
    logic        pushed;
    logic        rnd_ready = 1'b0;
    logic        chk_syn   = 1'b0;

    // H-matrix column of each data bit over c4..c0
    logic [4:0] hcol [8] = '{5'b00111, 5'b01110, 5'b01101, 5'b01011,
                             5'b10011, 5'b10101, 5'b10110, 5'b11001};

    function automatic logic [4:0] checks(input logic [7:0] d);
        logic [4:0] c = 5'd0;
        for (int i = 0; i < 8; i++)
            if (d[i]) c = c ^ hcol[i];
        return c;
    endfunction

    function automatic logic [4:0] syndrome(input logic [12:0] cw);
        return checks(cw[12:5]) ^ cw[4:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One clock: check state against the model, then advance model and DUT together.
    task automatic tick();
        logic       push;
        logic       pop;
        logic [12:0] e;
        if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
        push = in_valid && (tb_occ != 2);
        pop  = out_ready && (tb_occ != 0);
        chk("in_ready", 32'(in_ready), 32'(tb_occ != 2));
        chk("out_valid", 32'(out_valid), 32'(tb_occ != 0));
        chk("inj_armed", 32'(inj_armed), 32'(tb_armed));
        chk("code_count", 32'(code_count), 32'(tb_cnt));
        if (tb_occ != 0) chk("out_code", 32'(out_code), 32'(sb[0]));
        if (pop) begin
            if (chk_syn) chk("syndrome", 32'(syndrome(out_code)), 32'd0);
            void'(sb.pop_front());
            tb_cnt = tb_cnt + 16'd1;
            tb_occ--;
        end
        if (push) begin
            e = use_exp ? exp_code
                        : ({in_data, checks(in_data)} ^ (tb_armed ? tb_mask : 13'd0));
            sb.push_back(e);
            tb_occ++;
        end
        pushed = push;
        if (inj_load) begin
            tb_armed = 1'b1;
            tb_mask  = inj_mask;
        end else if (push && tb_armed) begin
            tb_armed = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] d, input logic [12:0] e, input logic use_e);
        int budget = 40;
        in_valid = 1'b1;
        in_data  = d;
        use_exp  = use_e;
        exp_code = e;
        pushed   = 1'b0;
        while (!pushed && budget > 0) begin
            tick();
            budget--;
        end
        if (!pushed) chk("send_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
        use_exp  = 1'b0;
    endtask

    task automatic load_mask(input logic [12:0] m);
        inj_load = 1'b1;
        inj_mask = m;
        tick();
        inj_load = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
    endtask

    logic [7:0] perm [256];

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = 8'd0; out_ready = 1'b0;
        inj_load = 1'b0; inj_mask = 13'd0;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_code", 32'(out_code), 32'd0);
        chk("rst_inj_armed", 32'(inj_armed), 32'd0);
        chk("rst_code_count", 32'(code_count), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic encode with constants from the code table
        out_ready = 1'b1;
        send(8'h00, 13'h0000, 1'b1);
        send(8'hFF, 13'h1FE6, 1'b1);
        send(8'h01, 13'h0027, 1'b1);
        send(8'h80, 13'h1019, 1'b1);
        tick();
        chk("basic_count", 32'(code_count), 32'd4);

        // Backpressure, then full with simultaneous pop
        out_ready = 1'b0;
        in_valid = 1'b1; use_exp = 1'b1;
        in_data = 8'h01; exp_code = 13'h0027; tick();
        in_data = 8'h80; exp_code = 13'h1019; tick();
        in_data = 8'hFF; exp_code = 13'h1FE6; tick();
        chk("bp_full", 32'(in_ready), 32'd0);
        tick();
        out_ready = 1'b1;
        tick();
        chk("full_pop_refused", 32'(tb_occ), 32'd1);
        tick();
        chk("full_pop_next", 32'(pushed), 32'd1);
        in_valid = 1'b0; use_exp = 1'b0;
        drain();

        // Injection
        load_mask(13'h0020);
        chk("armed_after_load", 32'(inj_armed), 32'd1);
        send(8'h00, 13'h0020, 1'b1);
        chk("armed_cleared", 32'(inj_armed), 32'd0);
        send(8'h00, 13'h0000, 1'b1);
        load_mask(13'h0003);
        send(8'hFF, 13'h1FE5, 1'b1);
        drain();

        // Load coincident with accept while idle
        inj_load = 1'b1; inj_mask = 13'h1000;
        send(8'h01, 13'h0027, 1'b1);
        inj_load = 1'b0;
        send(8'h01, 13'h1027, 1'b1);
        // Double load: second mask wins
        load_mask(13'h0001);
        load_mask(13'h0100);
        send(8'h80, 13'h1119, 1'b1);
        drain();

        // Reset mid-operation
        out_ready = 1'b0;
        send(8'h12, 13'd0, 1'b0);
        send(8'h34, 13'd0, 1'b0);
        load_mask(13'h0F0F);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_out_code", 32'(out_code), 32'd0);
        chk("mid_rst_inj_armed", 32'(inj_armed), 32'd0);
        chk("mid_rst_count", 32'(code_count), 32'd0);
        sb.delete(); tb_occ = 0; tb_armed = 1'b0; tb_mask = 13'd0; tb_cnt = 16'd0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();

        // Random-order sweep of all data values, checked against the model and by syndrome
        for (int i = 0; i < 256; i++) perm[i] = 8'(i);
        for (int i = 255; i > 0; i--) begin
            int j;
            logic [7:0] t;
            j = $urandom_range(0, i);
            t = perm[i]; perm[i] = perm[j]; perm[j] = t;
        end
        rnd_ready = 1'b1;
        chk_syn   = 1'b1;
        for (int i = 0; i < 256; i++) send(perm[i], 13'd0, 1'b0);
        rnd_ready = 1'b0;
        drain();
        chk("sweep_count", 32'(code_count), 32'(16'd256));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
